// File: rtl/des_decrypt_core.sv
// Iterative DES engine: one Feistel round per clock, valid/ready on both sides.
// Optional DES_ENCRYPT_EN adds an encrypt port and left-rotating key schedule.

module s1 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    // Row = outer bits {b5,b0}, column = inner bits b4..b1; entry 0 sits at the top nibble.
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module s2 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module s3 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module s4 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module s5 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module s6 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module s7 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module s8 (input logic [5:0] b, output logic [3:0] o);
    localparam logic [255:0] TBL = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    assign o = 4'(TBL >> (9'd252 - {1'b0, b[5], b[0], b[4:1], 2'b00}));
endmodule

module des_decrypt_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ciphertext,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plaintext,
    output logic        busy
`ifdef DES_ENCRYPT_EN
    ,
    input  logic        encrypt
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Tables hold 1-based DES bit numbers; DES bit n lives at vector index (width - n).
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        ip_f = '0;
        for (int i = 0; i < 64; i++) ip_f[6'(63 - i)] = x[6'(64 - IP_T[i])];
    endfunction

    // Final permutation is the inverse of IP, so it reuses the IP table.
    function automatic logic [63:0] fp_f(input logic [63:0] x);
        fp_f = '0;
        for (int i = 0; i < 64; i++) fp_f[6'(64 - IP_T[i])] = x[6'(63 - i)];
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] x);
        e_f = '0;
        for (int i = 0; i < 48; i++) e_f[6'(47 - i)] = x[5'(32 - E_T[i])];
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        p_f = '0;
        for (int i = 0; i < 32; i++) p_f[5'(31 - i)] = x[5'(32 - P_T[i])];
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        pc1_f = '0;
        for (int i = 0; i < 56; i++) pc1_f[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        pc2_f = '0;
        for (int i = 0; i < 48; i++) pc2_f[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd0:    rotr = x;
            2'd1:    rotr = {x[0], x[27:1]};
            default: rotr = {x[1:0], x[27:2]};
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  rnd_q, rnd_d;
    logic        fin_q, fin_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [55:0] cd_q, cd_d, cd_rot;
    logic [63:0] pt_q, pt_d;
    logic [47:0] sbox_in;
    logic [31:0] sbox_out;
    logic [1:0]  sh_dec;
    logic        unused_key_parity;

    assign unused_key_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
    assign sh_dec = (rnd_q == 4'd0) ? 2'd0 :
                    (rnd_q == 4'd1 || rnd_q == 4'd8 || rnd_q == 4'd15) ? 2'd1 : 2'd2;

`ifdef DES_ENCRYPT_EN
    logic        mode_q, mode_d;
    logic [1:0]  sh_enc;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        rotl = (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    assign sh_enc = (rnd_q == 4'd0 || rnd_q == 4'd1 || rnd_q == 4'd8 || rnd_q == 4'd15) ? 2'd1 : 2'd2;
    assign cd_rot = mode_q ? {rotl(cd_q[55:28], sh_enc), rotl(cd_q[27:0], sh_enc)}
                           : {rotr(cd_q[55:28], sh_dec), rotr(cd_q[27:0], sh_dec)};
`else
    assign cd_rot = {rotr(cd_q[55:28], sh_dec), rotr(cd_q[27:0], sh_dec)};
`endif

    assign sbox_in = e_f(r_q) ^ pc2_f(cd_rot);

    s1 u_s1 (.b(sbox_in[47:42]), .o(sbox_out[31:28]));
    s2 u_s2 (.b(sbox_in[41:36]), .o(sbox_out[27:24]));
    s3 u_s3 (.b(sbox_in[35:30]), .o(sbox_out[23:20]));
    s4 u_s4 (.b(sbox_in[29:24]), .o(sbox_out[19:16]));
    s5 u_s5 (.b(sbox_in[23:18]), .o(sbox_out[15:12]));
    s6 u_s6 (.b(sbox_in[17:12]), .o(sbox_out[11:8]));
    s7 u_s7 (.b(sbox_in[11:6]),  .o(sbox_out[7:4]));
    s8 u_s8 (.b(sbox_in[5:0]),   .o(sbox_out[3:0]));

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d = state_q;
        rnd_d   = rnd_q;
        fin_d   = fin_q;
        l_d     = l_q;
        r_d     = r_q;
        cd_d    = cd_q;
        pt_d    = pt_q;
`ifdef DES_ENCRYPT_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d    = S_ROUND;
                {l_d, r_d} = ip_f(ciphertext);
                cd_d       = pc1_f(key);
                rnd_d      = 4'd0;
                fin_d      = 1'b0;
`ifdef DES_ENCRYPT_EN
                mode_d     = encrypt;
`endif
            end
            // After the 16th round one more cycle latches the output permutation.
            S_ROUND: if (fin_q) begin
                pt_d    = fp_f({r_q, l_q});
                fin_d   = 1'b0;
                state_d = S_DONE;
            end else begin
                cd_d  = cd_rot;
                l_d   = r_q;
                r_d   = l_q ^ p_f(sbox_out);
                rnd_d = rnd_q + 4'd1;
                fin_d = (rnd_q == 4'd15);
            end
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            fin_q   <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            cd_q    <= '0;
            pt_q    <= '0;
`ifdef DES_ENCRYPT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            fin_q   <= fin_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cd_q    <= cd_d;
            pt_q    <= pt_d;
`ifdef DES_ENCRYPT_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign plaintext = pt_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core using published DES known-answer vectors.
// Encrypt-mode checks compile in only when DES_ENCRYPT_EN is defined.

module tb_des_decrypt_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ciphertext;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;
    logic        busy;
    logic        encrypt;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY2P = 64'h0F339333EB6C0C72;
    localparam logic [63:0] CT2  = 64'h0000000000000000;
    localparam logic [63:0] PT2  = 64'h8787878787878787;

    des_decrypt_core dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ciphertext(ciphertext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .plaintext(plaintext), .busy(busy)
`ifdef DES_ENCRYPT_EN
        , .encrypt(encrypt)
`endif
    );

    always #5 clk = ~clk;

    // Accepts one block on the next edge, scrambles the inputs, then waits for out_valid.
    task automatic run_block(input logic [63:0] ct, input logic [63:0] k,
                             output logic [63:0] pt, output int lat);
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ciphertext = ~ct;
        key        = ~k;
        lat = -1;
        pt  = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                pt  = plaintext;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; encrypt = 1'b0;
        ciphertext = '0; key = '0;
        #2;
        vectors++;
        if ({in_ready, out_valid, busy, plaintext} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b pt=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, plaintext);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known_answer();
        logic [63:0] pt;
        int lat;
        out_ready = 1'b1;
        run_block(CT1, KEY1, pt, lat);
        vectors++;
        if (lat !== 17) begin
            miscompares++;
            $display("FAIL kat1_latency: got %0d, want 17", lat);
        end
        vectors++;
        if (pt !== PT1) begin
            miscompares++;
            $display("FAIL kat1_plaintext: got %h, want %h", pt, PT1);
        end
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL kat1_release: got vld/rdy/busy=%b, want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_parity();
        logic [63:0] pt;
        int lat;
        out_ready = 1'b1;
        run_block(CT2, KEY2, pt, lat);
        vectors++;
        if (pt !== PT2 || lat !== 17) begin
            miscompares++;
            $display("FAIL kat2_plaintext: got %h lat %0d, want %h lat 17", pt, lat, PT2);
        end
        @(posedge clk); #1;
        run_block(CT2, KEY2P, pt, lat);
        vectors++;
        if (pt !== PT2 || lat !== 17) begin
            miscompares++;
            $display("FAIL kat2_parity_key: got %h lat %0d, want %h lat 17", pt, lat, PT2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [63:0] pt;
        int lat;
        out_ready = 1'b0;
        run_block(CT1, KEY1, pt, lat);
        vectors++;
        if (pt !== PT1 || lat !== 17) begin
            miscompares++;
            $display("FAIL bp_plaintext: got %h lat %0d, want %h lat 17", pt, lat, PT1);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid   = (i % 2 == 0);
            ciphertext = {$urandom, $urandom};
            key        = {$urandom, $urandom};
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, in_ready, busy, plaintext} !== {1'b1, 1'b0, 1'b1, PT1}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b busy=%b pt=%h, want 1 0 1 %h",
                         i, out_valid, in_ready, busy, plaintext, PT1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_transfer: got vld/rdy/busy=%b, want 010", {out_valid, in_ready, busy});
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_no_ghost: got vld/busy=%b, want 00", {out_valid, busy});
        end
    endtask

    task automatic test_reset_mid_round();
        logic [63:0] pt;
        int lat;
        out_ready  = 1'b1;
        ciphertext = CT1;
        key        = KEY1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, plaintext} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            miscompares++;
            $display("FAIL midreset_async: got rdy=%b vld=%b busy=%b pt=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, plaintext);
        end
        @(posedge clk); #1;
        vectors++;
        if ({in_ready, out_valid, busy, plaintext} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            miscompares++;
            $display("FAIL midreset_held: got rdy=%b vld=%b busy=%b pt=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, plaintext);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_block(CT2, KEY2P, pt, lat);
        vectors++;
        if (pt !== PT2 || lat !== 17) begin
            miscompares++;
            $display("FAIL midreset_restart: got %h lat %0d, want %h lat 17", pt, lat, PT2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] p1, p2;
        int o1, o2, acc2;
        out_ready  = 1'b1;
        ciphertext = CT1;
        key        = KEY1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        ciphertext = CT2;
        key        = KEY2;
        o1 = -1; o2 = -1; acc2 = -1; p1 = '0; p2 = '0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (o1 < 0) begin o1 = c; p1 = plaintext; end
                else if (o2 < 0) begin o2 = c; p2 = plaintext; end
            end
            if (c == acc2) in_valid = 1'b0;
            if (in_ready && in_valid && acc2 < 0) acc2 = c + 1;
        end
        in_valid = 1'b0;
        vectors++;
        if (o1 !== 17 || p1 !== PT1) begin
            miscompares++;
            $display("FAIL b2b_first: got cycle %0d pt %h, want cycle 17 pt %h", o1, p1, PT1);
        end
        vectors++;
        if (acc2 !== 19) begin
            miscompares++;
            $display("FAIL b2b_accept_gap: got %0d, want 19", acc2);
        end
        vectors++;
        if (o2 !== 36 || p2 !== PT2) begin
            miscompares++;
            $display("FAIL b2b_second: got cycle %0d pt %h, want cycle 36 pt %h", o2, p2, PT2);
        end
    endtask

`ifdef DES_ENCRYPT_EN
    task automatic test_encrypt();
        logic [63:0] pt;
        int lat;
        out_ready = 1'b1;
        encrypt   = 1'b1;
        run_block(PT1, KEY1, pt, lat);
        vectors++;
        if (pt !== CT1 || lat !== 17) begin
            miscompares++;
            $display("FAIL enc_kat: got %h lat %0d, want %h lat 17", pt, lat, CT1);
        end
        @(posedge clk); #1;
        encrypt = 1'b0;
        run_block(pt, KEY1, pt, lat);
        vectors++;
        if (pt !== PT1 || lat !== 17) begin
            miscompares++;
            $display("FAIL enc_roundtrip: got %h lat %0d, want %h lat 17", pt, lat, PT1);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_known_answer();
        test_parity();
        test_backpressure();
        test_reset_mid_round();
        test_back_to_back();
`ifdef DES_ENCRYPT_EN
        test_encrypt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
